// File: rtl/alu_flag_queue.sv
// Output stage behind the add/sub unit: NZCV flag derivation, result FIFO,
// architectural flag register and saturating overflow counter.
// Optional sticky overflow output enabled by defining ALU_FLAG_QUEUE_STICKY_OVF_EN.
module alu_flag_queue #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_result,
   input  logic             in_carry,
   input  logic             in_overflow,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic [3:0]       out_flags,
   output logic [3:0]       flags_q,
   output logic [15:0]      ovf_count,
`ifdef ALU_FLAG_QUEUE_STICKY_OVF_EN
   output logic             ovf_sticky,
`endif
   input  logic             clr_count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH+3:0] mem_q [DEPTH];
   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic [3:0]       flags_d;
   logic [15:0]      ovf_cnt_q, ovf_cnt_d;
   logic [3:0]       push_flags;
   logic [WIDTH+3:0] head;
   logic             full, empty, push, pop;

   // Pointer MSB toggles on each wrap, so equal index bits mean full or empty.
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign empty = (wr_ptr_q == rd_ptr_q);

   assign push = in_valid && !full;
   assign pop  = !empty && out_ready;

   assign push_flags = {in_result[WIDTH-1], (in_result == '0), in_carry, in_overflow};

   assign head       = mem_q[rd_ptr_q[AW-1:0]];
   assign in_ready   = !full;
   assign out_valid  = !empty;
   assign out_result = empty ? '0 : head[WIDTH-1:0];
   assign out_flags  = empty ? '0 : head[WIDTH+3:WIDTH];
   assign ovf_count  = ovf_cnt_q;

   always_comb begin
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      flags_d   = flags_q;
      ovf_cnt_d = ovf_cnt_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + (AW+1)'(1);
         flags_d  = push_flags;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + (AW+1)'(1);
      end
      // Clear takes priority over a same-cycle increment.
      if (clr_count) begin
         ovf_cnt_d = '0;
      end else if (push && in_overflow && (ovf_cnt_q != 16'hFFFF)) begin
         ovf_cnt_d = ovf_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         flags_q   <= '0;
         ovf_cnt_q <= '0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         flags_q   <= flags_d;
         ovf_cnt_q <= ovf_cnt_d;
      end
   end

   // Storage carries no reset; the pointers define which entries are live.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q[AW-1:0]] <= {push_flags, in_result};
      end
   end

`ifdef ALU_FLAG_QUEUE_STICKY_OVF_EN
   logic ovf_sticky_q, ovf_sticky_d;

   always_comb begin
      ovf_sticky_d = ovf_sticky_q;
      if (clr_count) begin
         ovf_sticky_d = 1'b0;
      end else if (push && in_overflow) begin
         ovf_sticky_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_sticky_q <= 1'b0;
      end else begin
         ovf_sticky_q <= ovf_sticky_d;
      end
   end

   assign ovf_sticky = ovf_sticky_q;
`endif

endmodule

// File: tb/tb_alu_flag_queue.sv
// Bench for alu_flag_queue: directed scenarios plus random traffic, checked
// against a queue-based reference model through an expected-result scoreboard.
module tb_alu_flag_queue;

   localparam int WIDTH = 32;
   localparam int DEPTH = 2;

   logic             clk;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_result;
   logic             in_carry;
   logic             in_overflow;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_result;
   logic [3:0]       out_flags;
   logic [3:0]       flags_q;
   logic [15:0]      ovf_count;
   logic             clr_count;

   alu_flag_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_result   (in_result),
      .in_carry    (in_carry),
      .in_overflow (in_overflow),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_result  (out_result),
      .out_flags   (out_flags),
      .flags_q     (flags_q),
      .ovf_count   (ovf_count),
      .clr_count   (clr_count)
   );

   // Reference model state: expected FIFO contents, occupancy, NZCV, counter.
   logic [WIDTH+3:0] exp_q [$];
   int               occ;
   logic [3:0]       m_flags;
   int               m_cnt;
   int               checks;
   int               failures;
   logic [3:0]       f_new;
   logic             acc;
   logic             pp;
   logic [WIDTH+3:0] exp_head;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic v, input logic [WIDTH-1:0] d, input logic c,
                        input logic ov, input logic rdy, input logic clr);
      in_valid    = v;
      in_result   = d;
      in_carry    = c;
      in_overflow = ov;
      out_ready   = rdy;
      clr_count   = clr;
      @(posedge clk);
      #2;
   endtask

   task automatic model_reset();
      exp_q.delete();
      occ     = 0;
      m_flags = 4'b0;
      m_cnt   = 0;
   endtask

   // Reference model: evaluates the cycle's transfer from pre-edge occupancy.
   always @(posedge clk) begin
      if (rst_n) begin
         acc   = in_valid && (occ < DEPTH);
         pp    = out_ready && (occ > 0);
         f_new = {in_result[WIDTH-1], (in_result == 0), in_carry, in_overflow};
         if (acc) begin
            exp_q.push_back({f_new, in_result});
            m_flags = f_new;
            if (in_overflow && m_cnt < 65535) m_cnt = m_cnt + 1;
         end
         if (clr_count) m_cnt = 0;
         occ = occ + int'(acc) - int'(pp);
      end
   end

   // Monitor: checks status against the model and retires the head on pop.
   always @(negedge clk) begin
      if (rst_n) begin
         check("in_ready", 64'(in_ready), 64'(occ < DEPTH));
         check("out_valid", 64'(out_valid), 64'(occ > 0));
         check("flags_q", 64'(flags_q), 64'(m_flags));
         check("ovf_count", 64'(ovf_count), 64'(m_cnt));
         if (exp_q.size() == 0) begin
            check("empty_out", 64'({out_flags, out_result}), 64'(0));
         end else if (out_valid && out_ready) begin
            exp_head = exp_q.pop_front();
            check("head", 64'({out_flags, out_result}), 64'(exp_head));
         end
      end
   end

   initial begin
      checks = 0;
      failures = 0;
      model_reset();
      rst_n = 1'b0;
      in_valid = 0; in_result = '0; in_carry = 0; in_overflow = 0;
      out_ready = 0; clr_count = 0;
      #22 rst_n = 1'b1;
      #1;
      check("rst_in_ready", 64'(in_ready), 64'(1));
      check("rst_out_valid", 64'(out_valid), 64'(0));
      check("rst_flags_q", 64'(flags_q), 64'(0));
      check("rst_ovf_count", 64'(ovf_count), 64'(0));
      check("rst_out_result", 64'(out_result), 64'(0));

      // Positive overflow result: only V set, visible at the push edge.
      drive(1, 32'h7FFF_FFFF, 0, 1, 1, 0);
      check("d1_out_valid", 64'(out_valid), 64'(1));
      check("d1_out_result", 64'(out_result), 64'h7FFF_FFFF);
      check("d1_out_flags", 64'(out_flags), 64'(4'b0001));
      check("d1_flags_q", 64'(flags_q), 64'(4'b0001));
      check("d1_ovf_count", 64'(ovf_count), 64'(1));

      // Zero result with carry: Z and C.
      drive(1, 32'h0, 1, 0, 1, 0);
      check("d2_out_flags", 64'(out_flags), 64'(4'b0110));
      check("d2_flags_q", 64'(flags_q), 64'(4'b0110));
      drive(0, 0, 0, 0, 1, 0);
      drive(0, 0, 0, 0, 1, 0);

      // Fill with consumer stalled; third push must be refused.
      drive(1, 32'h1, 0, 0, 0, 0);
      drive(1, 32'h2, 0, 0, 0, 0);
      check("full_in_ready", 64'(in_ready), 64'(0));
      drive(1, 32'h3, 1, 1, 0, 0);
      check("full_hold_in_ready", 64'(in_ready), 64'(0));
      check("full_head", 64'(out_result), 64'h1);
      check("full_flags_q", 64'(flags_q), 64'(4'b0000));
      drive(0, 0, 0, 0, 1, 0);
      check("drain_head", 64'(out_result), 64'h2);
      check("drain_in_ready", 64'(in_ready), 64'(1));
      drive(0, 0, 0, 0, 1, 0);
      check("drain_empty", 64'(out_valid), 64'(0));
      check("drain_flags_q", 64'(flags_q), 64'(4'b0000));

      // Saturation of the overflow counter, then clear beating an increment.
      for (int i = 0; i < 65540; i++) begin
         drive(1, $urandom, 1'($urandom_range(0, 1)), 1, 1, 0);
      end
      check("sat_ovf_count", 64'(ovf_count), 64'hFFFF);
      drive(1, $urandom, 0, 1, 1, 1);
      check("clr_ovf_count", 64'(ovf_count), 64'(0));

      // Streaming at occupancy 1, then asynchronous reset mid-stream.
      for (int i = 0; i < 8; i++) begin
         drive(1, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1, 0);
         check("stream_in_ready", 64'(in_ready), 64'(1));
      end
      rst_n = 1'b0;
      #1;
      check("arst_out_valid", 64'(out_valid), 64'(0));
      check("arst_in_ready", 64'(in_ready), 64'(1));
      check("arst_flags_q", 64'(flags_q), 64'(0));
      check("arst_ovf_count", 64'(ovf_count), 64'(0));
      model_reset();
      drive(0, 0, 0, 0, 0, 0);
      rst_n = 1'b1;

      // Random traffic with random backpressure and clears.
      for (int i = 0; i < 2000; i++) begin
         drive(1'($urandom_range(0, 2) != 0),
               ($urandom_range(0, 7) == 0) ? 32'h0 : 32'($urandom),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 31) == 0));
      end
      for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 1, 0);
      check("final_drained", 64'(exp_q.size()), 64'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/alu_flag_queue.md
# alu_flag_queue

Registered output stage placed directly downstream of the 32-bit add/sub unit. It captures each ALU result together with its carry and overflow, and derives the negative and zero flags locally. Results are queued in a small FIFO with a valid/ready handshake toward the consumer. The block also keeps an architectural NZCV flag register and a saturating overflow-event counter for the control path.

## Interface
- `WIDTH`, default 32: data width of the result path.
- `DEPTH`, default 2: number of FIFO entries. Must be a power of two and at least 2.
- `clk` input, 1 bit: single clock. All state changes on the rising edge.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `in_valid` input, 1 bit: the upstream ALU result is valid this cycle.
- `in_ready` output, 1 bit: the block can accept a result. Equals `!full`.
- `in_result` input, `WIDTH` bits: ALU result.
- `in_carry` input, 1 bit: ALU carry-out, as delivered (for subtraction, 1 means no borrow).
- `in_overflow` input, 1 bit: ALU signed-overflow bit.
- `out_valid` output, 1 bit: the FIFO head is valid.
- `out_ready` input, 1 bit: the consumer takes the head this cycle.
- `out_result` output, `WIDTH` bits: head result. Zero when empty.
- `out_flags` output, 4 bits: head flags `{N,Z,C,V}`. Zero when empty.
- `flags_q` output, 4 bits: architectural NZCV register, holding the flags of the last accepted result.
- `ovf_count` output, 16 bits: number of accepted results with V=1. Saturates.
- `clr_count` input, 1 bit: synchronous clear of `ovf_count` (and of the sticky flag when that feature is enabled).

## Operation
- Accept (push) occurs when `in_valid && in_ready`.
- Pop occurs when `out_valid && out_ready`.
- Flag derivation on push:
  - N = `in_result[WIDTH-1]`
  - Z = (`in_result` == 0), computed locally; there is no zero input.
  - C = `in_carry`
  - V = `in_overflow`
- FIFO storage:
  - Each entry holds `WIDTH`+4 bits.
  - Write and read pointers are `log2(DEPTH)`+1 bits wide; the MSB distinguishes full from empty across wrap-around.
  - full = same index bits with different MSB; empty = pointers equal.
- Full: `in_ready`=0 and no push. There is no bypass, so a pop in the same cycle does not allow a push; `in_ready` rises the cycle after the pop.
- Empty: `out_valid`=0. A pop is ignored.
- Simultaneous push and pop when neither full nor empty: both happen, and occupancy is unchanged.
- `flags_q` loads the pushed flags on every push and holds otherwise. It is independent of pops.
- `ovf_count`:
  - Increments by 1 on a push with V=1.
  - Saturates at 0xFFFF.
  - If `clr_count` is asserted in the same cycle as an incrementing push, clear wins and the count becomes 0.
- Pushes while `in_valid`=1 and `in_ready`=0 are dropped from this block's view. Upstream must hold its data, per standard valid/ready rules.

## Timing
- Reset values: pointers 0, `out_valid`=0, `in_ready`=1, `out_result`=0, `out_flags`=0, `flags_q`=0, `ovf_count`=0. FIFO contents are don't-care.
- Latency: a result pushed at edge k is visible on `out_*` with `out_valid`=1 from edge k onward, if the FIFO was empty. `flags_q` updates at the same edge.
- Output ordering is strictly FIFO.
- `out_result` and `out_flags` remain stable while `out_valid`=1 and `out_ready`=0.
- Throughput: 1 result per cycle when `out_ready` is held high.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronous). Queued entries are discarded.

## Configuration
- Macro: `ALU_FLAG_QUEUE_STICKY_OVF_EN`.
- When defined:
  - An extra output `ovf_sticky` (1 bit) is present.
  - It sets on any push with V=1 and stays set until `clr_count` or reset.
  - When clear and set occur in the same cycle, clear wins.
- When undefined: the port and its register are absent. All other behaviour is identical.

## Test plan
- Reset, then check idle outputs: `in_ready`=1, `out_valid`=0, `flags_q`=0, `ovf_count`=0.
- Push 0x7FFFFFFF with C=0, V=1 while `out_ready`=1. Expect head 0x7FFFFFFF with `out_flags`=0b0001, `flags_q`=0b0001, and `ovf_count`=1.
- Push 0x00000000 with C=1, V=0. Expect `out_flags`=0b0110 (Z and C set).
- With `out_ready`=0, push 0x1, 0x2, 0x3:
  - After the 2nd push, `in_ready`=0 and the 3rd is not accepted.
  - Raise `out_ready`: expect 0x1, then 0x2, in order.
  - `flags_q` holds the flags of 0x2.
- Drive 65540 pushes with V=1. Expect `ovf_count` to stick at 0xFFFF. Then pulse `clr_count` together with a V=1 push: expect 0.
- Push and pop simultaneously at occupancy 1 for 8 cycles: `in_ready` stays 1 throughout. Assert `rst_n`=0 mid-stream: `out_valid`=0 immediately.
